// File: rtl/fft_power_avg_pkg.sv
// Shared types and width helpers for the FFT bin power averager.
package fft_power_avg_pkg;

  typedef enum logic [1:0] {WAIT_SOP, FIRST, ACCUM, FINAL} state_t;

  function automatic int in_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int pwr_w(input int dw);
    return 2 * dw + 5;
  endfunction

  function automatic int acc_w(input int dw, input int al);
    return 2 * dw + 5 + al;
  endfunction

endpackage

// File: rtl/fft_power_avg_power_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM with a registered read port.
module power_acc_ram
  import fft_power_avg_pkg::*;
#(
  parameter int addr_w = 10,
  parameter int data_w = 40
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [addr_w-1:0] i_wr_addr,
  input  logic [data_w-1:0] i_wr_dat,
  input  logic [addr_w-1:0] i_rd_addr,
  output logic [data_w-1:0] o_rd_dat
);

  logic [data_w-1:0] r_mem [2**addr_w];
  logic [data_w-1:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
    r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/fft_power_avg.sv
// Averages per-bin power re^2+im^2 over 2^avg_log2 frames; 4-cycle latency, no stall.
module fft_power_avg
  import fft_power_avg_pkg::*;
#(
  parameter int data_width   = 16,
  parameter int fft_len_log2 = 10,
  parameter int avg_log2     = 3
) (
  input  logic                      clk_data_out,
  input  logic                      reset,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  input  logic signed [data_width+1:0] rr_scaled_shifted,
  input  logic signed [data_width+1:0] ri_scaled_shifted,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  output logic [2*data_width+4:0]   source_data,
  output logic                      frame_error
);

  localparam int IN_W  = in_w(data_width);
  localparam int PWR_W = pwr_w(data_width);
  localparam int ACC_W = acc_w(data_width, avg_log2);
  localparam int AW    = fft_len_log2;
  localparam logic [7:0] FRM_LAST = 8'((1 << avg_log2) - 1);

  state_t         r_state;
  logic [AW-1:0]  r_bin;
  logic [7:0]     r_frm;
  logic           r_err;
  logic           w_viol;

  logic                   r1_vld, r1_use_acc, r1_final, r1_sop, r1_eop;
  logic [AW-1:0]          r1_addr;
  logic signed [IN_W-1:0] r1_re, r1_im;

  logic                   r2_vld, r2_use_acc, r2_final, r2_sop, r2_eop;
  logic [AW-1:0]          r2_addr;
  logic [2*IN_W-1:0]      r2_re2, r2_im2;

  logic                   r3_vld, r3_use_acc, r3_final, r3_sop, r3_eop;
  logic [AW-1:0]          r3_addr;
  logic [PWR_W-1:0]       r3_pwr;
  logic [ACC_W-1:0]       r3_acc;

  logic signed [2*IN_W-1:0] w_re_x, w_im_x, w_re2, w_im2;
  logic [ACC_W-1:0]         w_rd_dat, w_sum;

  logic             r_src_vld, r_src_sop, r_src_eop;
  logic [PWR_W-1:0] r_src_dat;

  // Any flag that disagrees with the bin position breaks the frame.
  assign w_viol = (sink_sop && ((r_bin != '0) || sink_eop)) ||
                  (sink_eop && !(&r_bin)) ||
                  ((&r_bin) && !sink_eop) ||
                  ((r_bin == '0) && !sink_sop);

  always_ff @(posedge clk_data_out) begin
    if (reset) begin
      r_state <= WAIT_SOP;
      r_bin <= '0;
      r_frm <= '0;
      r_err <= 1'b0;
      r1_vld <= 1'b0;
      r1_use_acc <= 1'b0;
      r1_final <= 1'b0;
      r1_sop <= 1'b0;
      r1_eop <= 1'b0;
      r1_addr <= '0;
      r1_re <= '0;
      r1_im <= '0;
    end else begin
      r_err <= 1'b0;
      r1_vld <= 1'b0;
      r1_addr <= r_bin;
      r1_re <= rr_scaled_shifted;
      r1_im <= ri_scaled_shifted;
      r1_sop <= sink_sop;
      r1_eop <= sink_eop;
      if (sink_valid) begin
        if (r_state == WAIT_SOP) begin
          if (sink_sop && !sink_eop) begin
            r1_vld <= 1'b1;
            r1_use_acc <= 1'b0;
            r1_final <= (avg_log2 == 0);
            r_bin <= r_bin + 1'b1;
            r_frm <= '0;
            r_state <= (avg_log2 == 0) ? FINAL : FIRST;
          end else if (sink_sop) begin
            r_err <= 1'b1;
          end
        end else if (w_viol) begin
          r_err <= 1'b1;
          r_state <= WAIT_SOP;
          r_bin <= '0;
          r_frm <= '0;
        end else begin
          r1_vld <= 1'b1;
          r1_use_acc <= (r_state == ACCUM) || ((r_state == FINAL) && (avg_log2 != 0));
          r1_final <= (r_state == FINAL);
          r_bin <= r_bin + 1'b1;
          if (sink_eop) begin
            case (r_state)
              FIRST: begin
                r_frm <= 8'd1;
                r_state <= (avg_log2 == 1) ? FINAL : ACCUM;
              end
              ACCUM: begin
                r_frm <= r_frm + 8'd1;
                if (r_frm + 8'd1 == FRM_LAST) r_state <= FINAL;
              end
              default: begin
                r_frm <= '0;
                r_state <= WAIT_SOP;
              end
            endcase
          end
        end
      end
    end
  end

  assign w_re_x = {{IN_W{r1_re[IN_W-1]}}, r1_re};
  assign w_im_x = {{IN_W{r1_im[IN_W-1]}}, r1_im};
  assign w_re2  = w_re_x * w_re_x;
  assign w_im2  = w_im_x * w_im_x;

  always_ff @(posedge clk_data_out) begin
    if (reset) begin
      r2_vld <= 1'b0;
      r3_vld <= 1'b0;
      {r2_use_acc, r2_final, r2_sop, r2_eop} <= '0;
      {r3_use_acc, r3_final, r3_sop, r3_eop} <= '0;
      r2_addr <= '0;
      r3_addr <= '0;
      r2_re2 <= '0;
      r2_im2 <= '0;
      r3_pwr <= '0;
      r3_acc <= '0;
    end else begin
      r2_vld <= r1_vld;
      {r2_use_acc, r2_final, r2_sop, r2_eop} <= {r1_use_acc, r1_final, r1_sop, r1_eop};
      r2_addr <= r1_addr;
      r2_re2 <= w_re2;
      r2_im2 <= w_im2;
      r3_vld <= r2_vld;
      {r3_use_acc, r3_final, r3_sop, r3_eop} <= {r2_use_acc, r2_final, r2_sop, r2_eop};
      r3_addr <= r2_addr;
      r3_pwr <= PWR_W'(r2_re2) + PWR_W'(r2_im2);
      r3_acc <= w_rd_dat;
    end
  end

  // The first frame of a group overwrites whatever the RAM held from earlier groups.
  assign w_sum = r3_use_acc ? (r3_acc + ACC_W'(r3_pwr)) : ACC_W'(r3_pwr);

  power_acc_ram #(
    .addr_w(AW),
    .data_w(ACC_W)
  ) u_ram (
    .clk       (clk_data_out),
    .i_wr_en   (r3_vld && !r3_final),
    .i_wr_addr (r3_addr),
    .i_wr_dat  (w_sum),
    .i_rd_addr (r1_addr),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge clk_data_out) begin
    if (reset) begin
      r_src_vld <= 1'b0;
      r_src_sop <= 1'b0;
      r_src_eop <= 1'b0;
      r_src_dat <= '0;
    end else begin
      r_src_vld <= r3_vld && r3_final;
      r_src_sop <= r3_vld && r3_final && r3_sop;
      r_src_eop <= r3_vld && r3_final && r3_eop;
      if (r3_vld && r3_final) r_src_dat <= PWR_W'(w_sum >> avg_log2);
    end
  end

  assign source_valid = r_src_vld;
  assign source_sop   = r_src_sop;
  assign source_eop   = r_src_eop;
  assign source_data  = r_src_dat;
  assign frame_error  = r_err;

endmodule

// File: tb/tb_fft_power_avg.sv
// Two DUTs (avg_log2=2 and 3, N=8) driven in parallel and scored against a frame-level model.
module tb_fft_power_avg;

  localparam int N = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic signed [17:0] rr = '0, ri = '0;
  logic v0, s0, e0, fe0, v1, s1, e1, fe1;
  logic [36:0] d0, d1;

  always #5 clk = ~clk;

  fft_power_avg #(.data_width(16), .fft_len_log2(3), .avg_log2(2)) dut0 (
    .clk_data_out(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .rr_scaled_shifted(rr), .ri_scaled_shifted(ri),
    .source_valid(v0), .source_sop(s0), .source_eop(e0), .source_data(d0), .frame_error(fe0));

  fft_power_avg #(.data_width(16), .fft_len_log2(3), .avg_log2(3)) dut1 (
    .clk_data_out(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .rr_scaled_shifted(rr), .ri_scaled_shifted(ri),
    .source_valid(v1), .source_sop(s1), .source_eop(e1), .source_data(d1), .frame_error(fe1));

  typedef struct {int t; longint d; bit s; bit e;} exp_t;
  exp_t   q0[$], q1[$];
  int     total = 0, bad = 0, nneg = 0;
  bit     act[2];
  int     pos[2], nfr[2], err_exp[2], err_seen[2];
  longint acc[2][N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  // Frame-level reference: group of 2^avg frames summed per bin, last frame emitted.
  task automatic mdl(input int d, input bit s, input bit e, input longint p, input int t);
    int avg, g;
    exp_t x;
    avg = (d == 0) ? 2 : 3;
    g = 1 << avg;
    if (!act[d]) begin
      if (s && !e) begin
        act[d] = 1; pos[d] = 0; nfr[d] = 0;
      end else begin
        if (s) err_exp[d]++;
        return;
      end
    end else if ((s != (pos[d] == 0)) || (e != (pos[d] == N-1))) begin
      err_exp[d]++;
      act[d] = 0;
      return;
    end
    if (nfr[d] == 0) acc[d][pos[d]] = p;
    else acc[d][pos[d]] += p;
    if (nfr[d] == g-1) begin
      x.t = t; x.d = acc[d][pos[d]] >> avg; x.s = (pos[d] == 0); x.e = (pos[d] == N-1);
      if (d == 0) q0.push_back(x); else q1.push_back(x);
    end
    if (e) begin
      nfr[d]++; pos[d] = 0;
      if (nfr[d] == g) act[d] = 0;
    end else pos[d]++;
  endtask

  task automatic mon(input int d, input logic v, input logic s, input logic e, input logic [36:0] dat);
    exp_t x;
    if (v !== 1'b1) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk($sformatf("spurious_out%0d", d), 64'd1, 64'd0);
      return;
    end
    if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
    chk($sformatf("out_time%0d", d), 64'(nneg), 64'(x.t));
    chk($sformatf("out_data%0d", d), 64'(dat), x.d);
    chk($sformatf("out_sop%0d", d), 64'(s), 64'(x.s));
    chk($sformatf("out_eop%0d", d), 64'(e), 64'(x.e));
  endtask

  always @(negedge clk) begin
    nneg++;
    mon(0, v0, s0, e0, d0);
    mon(1, v1, s1, e1, d1);
    if (fe0 === 1'b1) err_seen[0]++;
    if (fe1 === 1'b1) err_seen[1]++;
  end

  task automatic drive(input bit v, input bit s, input bit e, input int re, input int im);
    longint p;
    sink_valid = v; sink_sop = s; sink_eop = e;
    rr = 18'(re); ri = 18'(im);
    @(posedge clk);
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    if (v) begin
      mdl(0, s, e, p, nneg + 4);
      mdl(1, s, e, p, nneg + 4);
    end
    @(negedge clk);
  endtask

  task automatic frame(input bit rnd, input int re, input int im, input int gap);
    for (int b = 0; b < N; b++) begin
      while (int'($urandom_range(0, 99)) < gap) drive(0, 0, 0, rnd18(), rnd18());
      if (rnd) drive(1, b == 0, b == N-1, rnd18(), rnd18());
      else drive(1, b == 0, b == N-1, re, im);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sink_valid = 1'b0;
    @(posedge clk);
    q0.delete(); q1.delete();
    act[0] = 0; act[1] = 0;
    @(negedge clk);
    chk("rst_vld0", 64'(v0), 64'd0);
    chk("rst_vld1", 64'(v1), 64'd0);
    chk("rst_dat0", 64'(d0), 64'd0);
    reset = 1'b0;
  endtask

  task automatic flush();
    repeat (8) drive(0, 0, 0, 0, 0);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("ferr_cnt0", 64'(err_seen[0]), 64'(err_exp[0]));
    chk("ferr_cnt1", 64'(err_seen[1]), 64'(err_exp[1]));
    do_reset();
  endtask

  initial begin
    int base0, base1, b;
    bit fs, fe;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vld0", 64'(v0), 64'd0);   chk("reset_vld1", 64'(v1), 64'd0);
    chk("reset_sop0", 64'(s0), 64'd0);   chk("reset_sop1", 64'(s1), 64'd0);
    chk("reset_eop0", 64'(e0), 64'd0);   chk("reset_eop1", 64'(e1), 64'd0);
    chk("reset_dat0", 64'(d0), 64'd0);   chk("reset_dat1", 64'(d1), 64'd0);
    chk("reset_ferr0", 64'(fe0), 64'd0); chk("reset_ferr1", 64'(fe1), 64'd0);
    reset = 1'b0;

    // Constant 3+4j: every bin averages to 25.
    repeat (4) frame(0, 3, 4, 0);
    flush();

    // Full-scale negative inputs: 2^35 per bin with no wrap.
    repeat (8) frame(0, -131072, -131072, 0);
    flush();

    // Frame values 1..4 truncate to 7.
    for (int f = 1; f <= 4; f++) frame(0, f, 0, 0);
    flush();

    // Random data with 50% valid gaps.
    repeat (8) frame(1, 0, 0, 50);
    flush();

    // sop at bin 5 of frame 2 kills the group; the following group must be clean.
    base0 = err_seen[0]; base1 = err_seen[1];
    frame(1, 0, 0, 0);
    for (int i = 0; i < N; i++) drive(1, (i == 0) || (i == 5), i == N-1, rnd18(), rnd18());
    repeat (3) drive(0, 0, 0, 0, 0);
    chk("sop_err0", 64'(err_seen[0] - base0), 64'd1);
    chk("sop_err1", 64'(err_seen[1] - base1), 64'd1);
    chk("sop_err_noout0", 64'(q0.size()), 64'd0);
    repeat (8) frame(1, 0, 0, 20);
    flush();

    // Random framing corruption with gaps.
    b = 0;
    for (int i = 0; i < 600; i++) begin
      fs = (b == 0); fe = (b == N-1);
      if ($urandom_range(0, 99) < 4) fs = !fs;
      if ($urandom_range(0, 99) < 4) fe = !fe;
      if ($urandom_range(0, 99) < 30) drive(0, 0, 0, rnd18(), rnd18());
      else begin
        drive(1, fs, fe, rnd18(), rnd18());
        b = (b + 1) % N;
      end
    end
    flush();

    // Reset in the middle of the output frame of dut0.
    repeat (3) frame(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, i == 0, 1'b0, rnd18(), rnd18());
    do_reset();
    repeat (8) frame(1, 0, 0, 0);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
